bcd_seven_seg_display: RTL and testbench
========================================

// Module: bcd_seven_seg_display
// PURPOSE
//   Converts a 10-bit unsigned binary value into four BCD digits: thousands, hundreds, tens and ones.
//   Drives four 7-segment displays from those digits.
//   Sits between the processor data path (ALU result or PC) and the board HEX displays.
//   Replaces the separate combinational binary-to-BCD and digit-decoder pair with one registered block.
// PARAMETERS
//   BLANK_LEADING  0  1: leading-zero digits are blanked (the ones digit is never blanked); 0: all digits shown
//   SEG_ACTIVE_LOW 1  1: segment on = 0 (DE-board style); 0: segment on = 1
// PORTS
//   clock    in   1   single clock; all state updates on its rising edge
//   reset    in   1   synchronous, active-high reset
//   en       in   1   1: sample binary this cycle; 0: hold all outputs
//   binary   in  10   unsigned value, 0..1023
//   thous    out  4   BCD thousands digit (0 or 1)
//   hundreds out  4   BCD hundreds digit (0..9)
//   tens     out  4   BCD tens digit (0..9)
//   ones     out  4   BCD ones digit (0..9)
//   hex1     out  7   segments for ones;      bit0=a .. bit6=g
//   hex2     out  7   segments for tens
//   hex3     out  7   segments for hundreds
//   hex4     out  7   segments for thousands
// BEHAVIOUR
//   - Clock and reset:
//     - One clock domain (clock). Reset is synchronous, active-high, and wins over en.
//     - Reset values: thous = hundreds = tens = ones = 0.
//     - All hex outputs blank after reset: 7'h7F if SEG_ACTIVE_LOW, else 7'h00.
//   - Latency and hold:
//     - Rising edge with en=1 and reset=0 captures the conversion of binary.
//     - Digits and segments are registered, so the new value appears 1 cycle after sampling.
//     - Back-to-back samples give one result per cycle.
//     - en=0: every output holds its last value.
//   - Conversion:
//     - Exact decimal: binary = 1000*thous + 100*hundreds + 10*tens + ones.
//     - Implement as combinational shift-add-3 (double dabble) over 10 iterations: before each shift, add 3 to any 4-bit digit column >= 5.
//     - 1000..1023 gives thous=1. No digit ever exceeds 9.
//   - Segment decode (active-low codes g..a; invert all when SEG_ACTIVE_LOW=0):
//     - 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//     - 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000
//     - The decoder also maps 10..15 to A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110. These codes are unreachable from the converter but must be present.
//   - Leading-zero blanking (BLANK_LEADING=1):
//     - hex4 blank when thous=0.
//     - hex3 blank when thous=0 and hundreds=0.
//     - hex2 blank when thous, hundreds and tens are all 0.
//     - hex1 is always shown (0 shows "0").
//     - Digit outputs are unaffected by blanking.
//   - Boundaries: binary=0 -> all digits 0; binary=1023 -> 1,0,2,3.
//   - Simultaneous events: reset and en both high -> reset result.
//   - Reset mid-stream discards the pending sample; the next en=1 edge after reset deasserts loads normally.
// TESTING
//   - reset=1 for 2 cycles -> digits 0, hex1..hex4 = 7'h7F (defaults).
//   - en=1, binary=10'd0 -> next cycle digits 0/0/0/0, hex1=7'b1000000; with BLANK_LEADING=1, hex2..hex4 = 7'h7F.
//   - binary=999 -> 0/9/9/9, hex1..hex3 = 7'b0010000; binary=1023 -> 1/0/2/3, hex4=7'b1111001, hex1=7'b0110000.
//   - binary=305 then en=0 and binary=77 -> outputs stay 0/3/0/5 until en=1, then next cycle 0/0/7/7.
//   - Sweep 0..1023 with en=1 every cycle -> each output matches the golden decimal split 1 cycle later; no digit > 9.
//   - reset and en both high with binary=512 -> reset values; SEG_ACTIVE_LOW=0 build -> 8 gives 7'h7F and reset gives 7'h00.

Source files
------------

// File: rtl/bcd_seven_seg_display.sv
// rtl/bcd_seven_seg_display.sv - registered 10-bit binary to 4-digit BCD converter with 7-segment drivers
//
// Ports:
//   clock    - single clock, all state updates on its rising edge
//   reset    - synchronous active-high reset, wins over en
//   en       - 1: sample binary this cycle; 0: hold all outputs
//   binary   - unsigned input value 0..1023
//   thous, hundreds, tens, ones - registered BCD digits
//   hex1..hex4 - registered segment drives for ones..thousands, bit0=a .. bit6=g
module bcd_seven_seg_display #(
    parameter bit BLANK_LEADING  = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [9:0] binary,
    output logic [3:0] thous,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4
);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    // Active-low segment codes, g..a.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            4'd10:   c = 7'b0001000;
            4'd11:   c = 7'b0000011;
            4'd12:   c = 7'b1000110;
            4'd13:   c = 7'b0100001;
            4'd14:   c = 7'b0000110;
            default: c = 7'b0001110;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] seg_drive(input logic [3:0] d);
        return SEG_ACTIVE_LOW ? seg_code(d) : ~seg_code(d);
    endfunction

    logic [15:0] bcd;
    logic        blank4;
    logic        blank3;
    logic        blank2;
    logic [6:0]  nxt_hex1;
    logic [6:0]  nxt_hex2;
    logic [6:0]  nxt_hex3;
    logic [6:0]  nxt_hex4;

    // Double dabble: binary bits enter the BCD column one per iteration,
    // MSB first; any column >= 5 is corrected before the shift so the
    // doubling carries cleanly into the next decimal column.
    always_comb begin
        bcd = 16'd0;
        for (int i = 9; i >= 0; i--) begin
            for (int d = 0; d < 4; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], binary[i]};
        end
    end

    // A column blanks only when it and every more significant column are
    // zero; the ones column is never blanked.
    always_comb begin
        blank4 = BLANK_LEADING && (bcd[15:12] == 4'd0);
        blank3 = blank4 && (bcd[11:8] == 4'd0);
        blank2 = blank3 && (bcd[7:4] == 4'd0);

        nxt_hex1 = seg_drive(bcd[3:0]);
        nxt_hex2 = blank2 ? SEG_OFF : seg_drive(bcd[7:4]);
        nxt_hex3 = blank3 ? SEG_OFF : seg_drive(bcd[11:8]);
        nxt_hex4 = blank4 ? SEG_OFF : seg_drive(bcd[15:12]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            thous    <= 4'd0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
            hex1     <= SEG_OFF;
            hex2     <= SEG_OFF;
            hex3     <= SEG_OFF;
            hex4     <= SEG_OFF;
        end else if (en) begin
            thous    <= bcd[15:12];
            hundreds <= bcd[11:8];
            tens     <= bcd[7:4];
            ones     <= bcd[3:0];
            hex1     <= nxt_hex1;
            hex2     <= nxt_hex2;
            hex3     <= nxt_hex3;
            hex4     <= nxt_hex4;
        end
    end

endmodule

// File: tb/tb_bcd_seven_seg_display.sv
// tb/tb_bcd_seven_seg_display.sv - self-checking bench for bcd_seven_seg_display
module tb_bcd_seven_seg_display;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic [9:0] binary;

    logic [3:0] b_th, b_hu, b_te, b_on;
    logic [6:0] b_h1, b_h2, b_h3, b_h4;
    logic [3:0] p_th, p_hu, p_te, p_on;
    logic [6:0] p_h1, p_h2, p_h3, p_h4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bcd_seven_seg_display #(.BLANK_LEADING(1'b1), .SEG_ACTIVE_LOW(1'b1)) u_blank (
        .clock(clock), .reset(reset), .en(en), .binary(binary),
        .thous(b_th), .hundreds(b_hu), .tens(b_te), .ones(b_on),
        .hex1(b_h1), .hex2(b_h2), .hex3(b_h3), .hex4(b_h4)
    );

    bcd_seven_seg_display #(.BLANK_LEADING(1'b0), .SEG_ACTIVE_LOW(1'b0)) u_plain (
        .clock(clock), .reset(reset), .en(en), .binary(binary),
        .thous(p_th), .hundreds(p_hu), .tens(p_te), .ones(p_on),
        .hex1(p_h1), .hex2(p_h2), .hex3(p_h3), .hex4(p_h4)
    );

    logic [6:0] seg_lo [10];
    int         pw [4];

    typedef struct {
        int         bin;
        logic [3:0] th, hu, te, on;
        logic [6:0] h1, h2, h3, h4;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_dig(input int v);
        logic [15:0] r;
        for (int p = 0; p < 4; p++) begin
            r[4*p +: 4] = 4'((v / pw[p]) % 10);
        end
        return r;
    endfunction

    // Segment word {hex4,hex3,hex2,hex1}; position p blanks when the value is below 10^p.
    function automatic logic [27:0] exp_hex(input int v, input bit bl, input bit al);
        logic [27:0] r;
        logic [6:0]  s;
        for (int p = 0; p < 4; p++) begin
            s = seg_lo[(v / pw[p]) % 10];
            if (!al) s = ~s;
            if (bl && p > 0 && v < pw[p]) s = al ? 7'h7F : 7'h00;
            r[7*p +: 7] = s;
        end
        return r;
    endfunction

    task automatic drive(input bit r, input bit e, input int v);
        @(negedge clock);
        reset  = r;
        en     = e;
        binary = 10'(v);
        @(posedge clock);
        #1;
    endtask

    task automatic check_state(input string tag, input int v, input bit in_reset);
        if (in_reset) begin
            chk({tag, "_b_dig"}, {b_th, b_hu, b_te, b_on}, 16'h0000);
            chk({tag, "_b_hex"}, {b_h4, b_h3, b_h2, b_h1}, {4{7'h7F}});
            chk({tag, "_p_dig"}, {p_th, p_hu, p_te, p_on}, 16'h0000);
            chk({tag, "_p_hex"}, {p_h4, p_h3, p_h2, p_h1}, {4{7'h00}});
        end else begin
            chk({tag, "_b_dig"}, {b_th, b_hu, b_te, b_on}, exp_dig(v));
            chk({tag, "_b_hex"}, {b_h4, b_h3, b_h2, b_h1}, exp_hex(v, 1'b1, 1'b1));
            chk({tag, "_p_dig"}, {p_th, p_hu, p_te, p_on}, exp_dig(v));
            chk({tag, "_p_hex"}, {p_h4, p_h3, p_h2, p_h1}, exp_hex(v, 1'b0, 1'b0));
        end
    endtask

    initial begin
        int  hv;
        bit  hr;
        int  v;
        bit  e;
        bit  r;
        logic [3:0] mx;

        seg_lo[0] = 7'b1000000; seg_lo[1] = 7'b1111001; seg_lo[2] = 7'b0100100;
        seg_lo[3] = 7'b0110000; seg_lo[4] = 7'b0011001; seg_lo[5] = 7'b0010010;
        seg_lo[6] = 7'b0000010; seg_lo[7] = 7'b1111000; seg_lo[8] = 7'b0000000;
        seg_lo[9] = 7'b0010000;
        pw[0] = 1; pw[1] = 10; pw[2] = 100; pw[3] = 1000;

        vecs[0] = '{0,    4'd0, 4'd0, 4'd0, 4'd0, 7'h40, 7'h7F, 7'h7F, 7'h7F};
        vecs[1] = '{999,  4'd0, 4'd9, 4'd9, 4'd9, 7'h10, 7'h10, 7'h10, 7'h7F};
        vecs[2] = '{1023, 4'd1, 4'd0, 4'd2, 4'd3, 7'h30, 7'h24, 7'h40, 7'h79};
        vecs[3] = '{305,  4'd0, 4'd3, 4'd0, 4'd5, 7'h12, 7'h40, 7'h30, 7'h7F};
        vecs[4] = '{7,    4'd0, 4'd0, 4'd0, 4'd7, 7'h78, 7'h7F, 7'h7F, 7'h7F};
        vecs[5] = '{40,   4'd0, 4'd0, 4'd4, 4'd0, 7'h40, 7'h19, 7'h7F, 7'h7F};
        vecs[6] = '{1000, 4'd1, 4'd0, 4'd0, 4'd0, 7'h40, 7'h40, 7'h40, 7'h79};
        vecs[7] = '{86,   4'd0, 4'd0, 4'd8, 4'd6, 7'h02, 7'h00, 7'h7F, 7'h7F};

        reset = 1'b1; en = 1'b0; binary = 10'd0;

        // Reset held two cycles.
        drive(1, 0, 0);
        drive(1, 0, 0);
        check_state("reset", 0, 1'b1);

        // Fixed vectors with hand-computed expectations.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, vecs[i].bin);
            chk($sformatf("vec%0d_dig", vecs[i].bin), {b_th, b_hu, b_te, b_on},
                {vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].on});
            chk($sformatf("vec%0d_hex", vecs[i].bin), {b_h4, b_h3, b_h2, b_h1},
                {vecs[i].h4, vecs[i].h3, vecs[i].h2, vecs[i].h1});
            chk($sformatf("vec%0d_pdig", vecs[i].bin), {p_th, p_hu, p_te, p_on},
                {vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].on});
        end

        // Active-high build: 8 lights everything, zeros shown in full.
        drive(0, 1, 8);
        chk("plain_8_hex1", p_h1, 7'h7F);
        chk("plain_8_upper", {p_h4, p_h3, p_h2}, {3{7'h3F}});

        // Hold with en=0, then release.
        drive(0, 1, 305);
        check_state("hold_load", 305, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 77);
            check_state("hold", 305, 1'b0);
        end
        drive(0, 1, 77);
        check_state("release", 77, 1'b0);

        // Reset together with en wins; next en edge loads normally.
        drive(1, 1, 512);
        check_state("rst_en", 0, 1'b1);
        drive(0, 1, 456);
        check_state("after_rst", 456, 1'b0);

        // Reset arriving while samples stream discards the pending one.
        drive(0, 1, 123);
        drive(1, 1, 321);
        check_state("mid_rst", 0, 1'b1);
        drive(0, 1, 654);
        check_state("mid_rst_resume", 654, 1'b0);

        // Back-to-back sweep over the full input range.
        for (int i = 0; i < 1024; i++) begin
            drive(0, 1, i);
            check_state("sweep", i, 1'b0);
            mx = b_th;
            if (b_hu > mx) mx = b_hu;
            if (b_te > mx) mx = b_te;
            if (b_on > mx) mx = b_on;
            chk("sweep_digit_max", {31'd0, (mx <= 4'd9)}, 32'd1);
        end

        // Random en/reset/value mix against the held-value model.
        hv = 1023;
        hr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            v = int'($urandom_range(0, 1023));
            e = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 39) == 0);
            drive(r, e, v);
            if (r) begin
                hr = 1'b1;
            end else if (e) begin
                hr = 1'b0;
                hv = v;
            end
            check_state("rand", hv, hr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
